// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - door controller state encoding and defaults
// Shared by door_ctrl and its bench: state enum and default travel time.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } door_state_t;

  // 1 s of door travel at the 50 Hz system clock
  localparam int TRAVEL_TICKS_DEF = 50;

endpackage

// File: rtl/door_ctrl_if.sv
// rtl/door_ctrl_if.sv - link between the door controller and the 2 s hold-timer pair
// Signals:
//   tmr_run   : timer count enable (controller -> timer)
//   tmr_clr_n : timer clear, active-low (controller -> timer)
//   hold_c100 : timer carry; its fall ends the hold (timer -> controller)
// Modports: master = door controller, slave = hold timer.
interface door_ctrl_if;
  logic tmr_run;
  logic tmr_clr_n;
  logic hold_c100;

  modport master (output tmr_run, output tmr_clr_n, input hold_c100);
  modport slave  (input tmr_run, input tmr_clr_n, output hold_c100);
endinterface

// File: rtl/door_ctrl_edge_det.sv
// rtl/door_ctrl_edge_det.sv - one-bit registered rise/fall detector
// Ports:
//   clk, rst : clock, synchronous active-high reset (previous value clears to 0)
//   d        : input level
//   rise     : d is 1 now and was 0 last cycle
//   fall     : d is 0 now and was 1 last cycle
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_prev;

  always_ff @(posedge clk) begin
    if (rst) d_prev <= 1'b0;
    else     d_prev <= d;
  end

  assign rise = d & ~d_prev;
  assign fall = ~d & d_prev;

endmodule

// File: rtl/door_ctrl.sv
// rtl/door_ctrl.sv - elevator car door controller driving the hold-timer pair
// Optional feature macro: DOOR_OBSTRUCT_EN (door-edge sensor reverses a close
// and blocks the close button during the hold).
// Ports:
//   clk, rst          : 50 Hz clock, synchronous active-high reset
//   arr               : car stopped level at a floor
//   btn_open/btn_close: door buttons, level
//   obstruct          : door-edge sensor (only with DOOR_OBSTRUCT_EN)
//   tmr               : hold-timer link (run, clear_n out; carry in)
//   motor_open/close  : door drive commands
//   door_closed       : door fully closed
//   depart_ok         : one-cycle pulse when a close completes
module door_ctrl
  import door_pkg::*;
#(
  parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arr,
  input  logic          btn_open,
  input  logic          btn_close,
  input  logic          obstruct,
  door_ctrl_if.master   tmr,
  output logic          motor_open,
  output logic          motor_close,
  output logic          door_closed,
  output logic          depart_ok
);

  localparam int PW = $clog2(TRAVEL_TICKS + 1);
  localparam logic [PW-1:0] POS_TOP = PW'(TRAVEL_TICKS);

  door_state_t   state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic          depart_nxt;
  logic          arr_rise, arr_fall_unused;
  logic          hold_fall, hold_rise_unused;
  logic          obs;

`ifdef DOOR_OBSTRUCT_EN
  assign obs = obstruct;
`else
  logic unused_obstruct;
  assign unused_obstruct = obstruct;
  assign obs = 1'b0;
`endif

  edge_det u_arr_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (arr),
    .rise (arr_rise),
    .fall (arr_fall_unused)
  );

  edge_det u_hold_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (tmr.hold_c100),
    .rise (hold_rise_unused),
    .fall (hold_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLOSED;
      pos       <= '0;
      depart_ok <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      depart_ok <= depart_nxt;
    end
  end

  // Transitions are taken on the cycle whose position update lands on the
  // end stop, so a full stroke spends exactly TRAVEL_TICKS cycles in motion.
  // Direction changes leave pos untouched, so a reopen retraces only the
  // distance already closed.
  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    depart_nxt = 1'b0;
    case (state)
      CLOSED: begin
        if (arr_rise || (arr && btn_open)) state_nxt = OPENING;
      end
      OPENING: begin
        if (!arr) begin
          state_nxt = CLOSING;
        end else begin
          if (pos != POS_TOP) pos_nxt = pos + PW'(1);
          if (pos >= POS_TOP - PW'(1)) state_nxt = OPEN_HOLD;
        end
      end
      OPEN_HOLD: begin
        if (!arr)                     state_nxt = CLOSING;
        else if (btn_open)            state_nxt = OPEN_HOLD;
        else if (btn_close && !obs)   state_nxt = CLOSING;
        else if (hold_fall)           state_nxt = CLOSING;
      end
      CLOSING: begin
        // Reopen request wins over completing the close in the same cycle.
        if (arr && (btn_open || obs)) begin
          state_nxt = OPENING;
        end else begin
          if (pos != '0) pos_nxt = pos - PW'(1);
          if (pos <= PW'(1)) begin
            state_nxt  = CLOSED;
            depart_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = CLOSED;
    endcase
  end

  assign motor_open    = (state == OPENING);
  assign motor_close   = (state == CLOSING);
  assign door_closed   = (state == CLOSED);
  assign tmr.tmr_run   = (state == OPEN_HOLD);
  // Combinational on btn_open so the timer clears in the same cycle as the press.
  assign tmr.tmr_clr_n = (state == OPEN_HOLD) && !btn_open;

endmodule

// File: tb/tb_door_ctrl.sv
// tb/tb_door_ctrl.sv - scoreboard bench for door_ctrl with a modelled hold timer
module tb_door_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arr = 1'b0;
  logic btn_open = 1'b0;
  logic btn_close = 1'b0;
  logic obstruct = 1'b0;
  logic motor_open, motor_close, door_closed, depart_ok;

  door_ctrl_if tmr_if ();

  door_ctrl #(.TRAVEL_TICKS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .arr         (arr),
    .btn_open    (btn_open),
    .btn_close   (btn_close),
    .obstruct    (obstruct),
    .tmr         (tmr_if.master),
    .motor_open  (motor_open),
    .motor_close (motor_close),
    .door_closed (door_closed),
    .depart_ok   (depart_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hold-timer pair model: counts 00..99 while enabled, clear wins;
  // carry is high at 99 and falls when the count wraps to 00.
  int tcnt = 0;
  always @(posedge clk) begin
    if (!tmr_if.tmr_clr_n)   tcnt <= 0;
    else if (tmr_if.tmr_run) tcnt <= (tcnt == 99) ? 0 : tcnt + 1;
  end
  assign tmr_if.hold_c100 = (tcnt == 99);

  // Output vector {door_closed, motor_open, motor_close, tmr_run, tmr_clr_n, depart_ok}
  localparam logic [5:0] O_CL   = 6'b100000;
  localparam logic [5:0] O_OPN  = 6'b010000;
  localparam logic [5:0] O_HOLD = 6'b000110;
  localparam logic [5:0] O_HBTN = 6'b000100;
  localparam logic [5:0] O_CLS  = 6'b001000;
  localparam logic [5:0] O_DEP  = 6'b100001;

  typedef struct {
    logic [5:0] outs;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [5:0] prev_outs = 6'h3f;

  task automatic expect_at(input logic [5:0] o, input int c);
    exp_t e;
    e.outs = o;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge clk) begin
    logic [5:0] outs;
    exp_t e;
    if (mon_en) begin
      outs = {door_closed, motor_open, motor_close, tmr_if.tmr_run, tmr_if.tmr_clr_n, depart_ok};
      if (outs != prev_outs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d outs=%b", cyc, outs);
        end else begin
          e = exp_q.pop_front();
          if (outs != e.outs || cyc != e.cyc) begin
            errors++;
            $display("FAIL out_event got outs=%b cyc=%0d expected outs=%b cyc=%0d",
                     outs, cyc, e.outs, e.cyc);
          end
        end
      end
      prev_outs = outs;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;

    // Reset held 2 cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_at(O_CL, cyc);
    mon_en = 1'b1;

    // Full cycle: open, 100-count hold, close, depart
    wait_until(5);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_HOLD, n + 5);
    expect_at(O_CLS, n + 106);
    expect_at(O_DEP, n + 110);
    expect_at(O_CL, n + 111);
    wait_until(n + 115);
    arr = 1'b0;

    // Open pressed at timer count 60 restarts the hold
    wait_until(n + 118);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_HOLD, n + 5);
    expect_at(O_HBTN, n + 65);
    expect_at(O_HOLD, n + 66);
    expect_at(O_CLS, n + 167);
    expect_at(O_DEP, n + 171);
    expect_at(O_CL, n + 172);
    wait_until(n + 65);
    btn_open = 1'b1;
    tick();
    btn_open = 1'b0;
    wait_until(n + 176);
    arr = 1'b0;

    // Close with open held stays open; close alone starts closing
    wait_until(n + 179);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_HOLD, n + 5);
    expect_at(O_HBTN, n + 10);
    expect_at(O_HOLD, n + 13);
    expect_at(O_CLS, n + 14);
    expect_at(O_DEP, n + 18);
    expect_at(O_CL, n + 19);
    wait_until(n + 10);
    btn_open = 1'b1;
    btn_close = 1'b1;
    wait_until(n + 13);
    btn_open = 1'b0;
    tick();
    btn_close = 1'b0;
    wait_until(n + 22);
    arr = 1'b0;

    // Reopen from CLOSING at pos=2: two cycles of opening, no departure
    wait_until(n + 25);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_HOLD, n + 5);
    expect_at(O_CLS, n + 7);
    expect_at(O_OPN, n + 10);
    expect_at(O_HOLD, n + 12);
    expect_at(O_CLS, n + 15);
    expect_at(O_DEP, n + 19);
    expect_at(O_CL, n + 20);
    wait_until(n + 6);
    btn_close = 1'b1;
    tick();
    btn_close = 1'b0;
    wait_until(n + 9);
    btn_open = 1'b1;
    tick();
    btn_open = 1'b0;
    wait_until(n + 14);
    arr = 1'b0;

    // Obstruction during CLOSING at pos=1
    wait_until(n + 24);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_HOLD, n + 5);
    expect_at(O_CLS, n + 7);
`ifdef DOOR_OBSTRUCT_EN
    expect_at(O_OPN, n + 11);
    expect_at(O_HOLD, n + 14);
    expect_at(O_CLS, n + 17);
    expect_at(O_DEP, n + 21);
    expect_at(O_CL, n + 22);
`else
    expect_at(O_DEP, n + 11);
    expect_at(O_CL, n + 12);
`endif
    wait_until(n + 6);
    btn_close = 1'b1;
    tick();
    btn_close = 1'b0;
    wait_until(n + 10);
    obstruct = 1'b1;
    tick();
    obstruct = 1'b0;
    wait_until(n + 16);
    arr = 1'b0;

    // Reset mid-opening forces CLOSED next cycle without a departure pulse
    wait_until(n + 26);
    n = cyc;
    arr = 1'b1;
    expect_at(O_OPN, n + 1);
    expect_at(O_CL, n + 4);
    wait_until(n + 3);
    rst = 1'b1;
    arr = 1'b0;
    tick();
    rst = 1'b0;
    wait_until(n + 10);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event expected outs=%b cyc=%0d got none", e.outs, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_ctrl.md
# door_ctrl

Elevator car door controller: the consumer side of the 2 s hold-timer interface. On car arrival it drives the door open, then arms and clears the hold timer. It closes the door on the timer's end-of-hold edge or on a close request, and reports when the car may depart. It sits between the car-motion logic (`arr`) and the hold-timer pair.

## Interface
- `TRAVEL_TICKS`, default 50: door travel time in `clk` cycles, full open or full close (1 s at 50 Hz). Legal range ≥ 2.
- `clk` in 1: system clock, 50 Hz.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `arr` in 1: car stopped level at a floor (level signal).
- `btn_open` in 1: door-open button, active-high, level.
- `btn_close` in 1: door-close button, active-high, level.
- `obstruct` in 1: door-edge sensor, active-high. Used only with `DOOR_OBSTRUCT_EN`.
- `hold_c100` in 1: hold-timer carry. Its falling edge marks the end of the 2 s hold.
- `tmr_run` out 1: hold-timer count enable. Drives the timer's arrival input.
- `tmr_clr_n` out 1: hold-timer clear, active-low.
- `motor_open` out 1: open-drive command.
- `motor_close` out 1: close-drive command.
- `door_closed` out 1: door fully closed.
- `depart_ok` out 1: one-cycle pulse when a close completes.

## Operation
States:
- **CLOSED**
  - Go to OPENING on a rising edge of `arr`, or when `arr & btn_open`.
- **OPENING**
  - `pos` increments each cycle. Go to OPEN_HOLD when `pos` reaches `TRAVEL_TICKS`.
  - If `arr`=0, go to CLOSING.
- **OPEN_HOLD**, priority high to low:
  1. `arr`=0 → CLOSING.
  2. `btn_open`=1 → stay; the timer is held cleared.
  3. `btn_close`=1 → CLOSING.
  4. Falling edge of `hold_c100` → CLOSING.
- **CLOSING**
  - `pos` decrements each cycle. Go to CLOSED when `pos` reaches 0, and pulse `depart_ok`.
  - Reopen when `arr & btn_open`, or `arr & obstruct` (macro on). The transition to OPENING keeps the current `pos`, so reopening takes the same time as the distance already closed.
  - A reopen request beats completion in the same cycle.

Position counter and edge detection:
- `pos` is `$clog2(TRAVEL_TICKS+1)` bits wide, saturates at 0 and `TRAVEL_TICKS`, and never wraps.
- Edge detectors register the previous `arr` and `hold_c100` every cycle, whatever the state. Their reset value is 0.
- A `hold_c100` fall is acted on only in OPEN_HOLD; falls in other states are discarded.

Output decode:
- `motor_open` = OPENING.
- `motor_close` = CLOSING.
- `door_closed` = CLOSED.
- `tmr_run` = OPEN_HOLD.
- `tmr_clr_n` = OPEN_HOLD & ~`btn_open`. The timer is therefore held at 00 in every other state, and restarts from 0 after each open press.
- `depart_ok` = registered pulse on the CLOSING→CLOSED transition.

## Timing
- Reset values:
  - State: CLOSED. `pos`=0.
  - Outputs: `door_closed`=1; `motor_open`, `motor_close`, `tmr_run`, `tmr_clr_n`, `depart_ok` all 0.
- Reset mid-operation forces CLOSED in the next cycle, even if the door is physically partly open. `depart_ok` is not pulsed.
- `arr` rises in cycle n → `motor_open`=1 from cycle n+1.
- A full open lasts exactly `TRAVEL_TICKS` cycles with `motor_open`=1; a full close lasts the same with `motor_close`=1.
- Falling edge of `hold_c100` sampled in cycle n → `motor_close`=1 from n+1.
- Registered outputs are decoded from state registers (Moore). The only exception is `tmr_clr_n`, which is combinational on `btn_open` so the clear takes effect the same cycle.

## Configuration
- `DOOR_OBSTRUCT_EN` defined:
  - `obstruct` reverses a close, same as `btn_open`.
  - If `obstruct` is asserted in OPEN_HOLD it blocks `btn_close`, but the hold timer still expires normally.
- Undefined: `obstruct` is unconnected internally and has no effect.

## Structure
- Package `door_pkg`:
  - State encoding: CLOSED=2'd0, OPENING=2'd1, OPEN_HOLD=2'd2, CLOSING=2'd3.
  - Default `TRAVEL_TICKS`.
- Sub-module `edge_det`: a one-bit registered rise/fall detector with synchronous reset. It is instantiated twice, once for `arr` and once for `hold_c100`.

## Test plan
All scenarios use `TRAVEL_TICKS`=4 with the real hold-timer pair attached, unless stated otherwise.
- Reset held 2 cycles → `door_closed`=1, all other outputs 0. Timer reads 00.
- `arr` rises → `motor_open` for exactly 4 cycles → `tmr_run`=1 → after 100 timer counts the `c100` fall → `motor_close` for 4 cycles → `depart_ok` one cycle → `door_closed`=1.
- In OPEN_HOLD, pulse `btn_open` at timer count 60 → `tmr_clr_n`=0 that cycle, timer restarts from 0, close begins 100 counts after release.
- In OPEN_HOLD, `btn_close` and `btn_open` asserted together → stays OPEN_HOLD. `btn_close` alone → `motor_close` next cycle.
- During CLOSING at `pos`=2, assert `btn_open` → OPENING for exactly 2 cycles, then OPEN_HOLD. No `depart_ok` pulse.
- With `DOOR_OBSTRUCT_EN`: `obstruct` during CLOSING at `pos`=1 → reopens, with no `depart_ok`. Without the macro: same stimulus → CLOSED and a `depart_ok` pulse.
